// File: rtl/keccak_round_control_if.sv
// keccak_round_control_if: start/done handshake, randomness and datapath strobes of the Keccak round sequencer
//   master: sponge wrapper side, drives StartxSI and RandValidxSI and observes the strobes
//   slave : sequencer side, drives ReadyxSO, BusyxSO, AbsorbxSO, StateEnxSO, RandReqxSO,
//           RoundNrxDO[4:0], PhasexDO[1:0], LastRoundxSO and DonexSO
interface keccak_round_control_if;
    logic       StartxSI;
    logic       RandValidxSI;
    logic       ReadyxSO;
    logic       BusyxSO;
    logic       AbsorbxSO;
    logic       StateEnxSO;
    logic       RandReqxSO;
    logic [4:0] RoundNrxDO;
    logic [1:0] PhasexDO;
    logic       LastRoundxSO;
    logic       DonexSO;
    modport master (
        output StartxSI, RandValidxSI,
        input  ReadyxSO, BusyxSO, AbsorbxSO, StateEnxSO, RandReqxSO,
        input  RoundNrxDO, PhasexDO, LastRoundxSO, DonexSO
    );
    modport slave (
        input  StartxSI, RandValidxSI,
        output ReadyxSO, BusyxSO, AbsorbxSO, StateEnxSO, RandReqxSO,
        output RoundNrxDO, PhasexDO, LastRoundxSO, DonexSO
    );
endinterface

// File: rtl/keccak_round_control.sv
// keccak_round_control: round sequencer for the masked (DOM) Keccak-f permutation
//   ClkxCI : clock, rising edge
//   RstxRI : synchronous active-high reset
//   bus    : slave side of keccak_round_control_if (start/done handshake, randomness
//            valid/request, state enable, absorb select, round number and phase)
module keccak_round_control #(
    parameter int NUM_ROUNDS   = 18,
    parameter int ROUND_CYCLES = 2
) (
    input  logic                  ClkxCI,
    input  logic                  RstxRI,
    keccak_round_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
    localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS - 1);
    localparam logic [1:0] LAST_PH  = 2'(ROUND_CYCLES - 1);
    state_e     state_q, state_d;
    logic [4:0] round_q, round_d;
    logic [1:0] phase_q, phase_d;
    logic       ready_q, busy_q, absorb_q, en_q, req_q, last_q, done_q;
    logic       stall;
    // a round may only start once fresh masking randomness is present
    assign stall = state_q == RUN && phase_q == 2'd0 && !bus.RandValidxSI;
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                round_d = '0;
                phase_d = '0;
                if (bus.StartxSI) state_d = LOAD;
            end
            LOAD: begin
                state_d = RUN;
                round_d = '0;
                phase_d = '0;
            end
            RUN: if (!stall) begin
                if (phase_q < LAST_PH) phase_d = phase_q + 2'd1;
                else begin
                    phase_d = '0;
                    if (round_q < LAST_RND) round_d = round_q + 5'd1;
                    else state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
                phase_d = '0;
            end
        endcase
    end
    // strobes are registered from the next-state values so they line up with the counters
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q  <= IDLE;
            round_q  <= '0;
            phase_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            absorb_q <= 1'b0;
            en_q     <= 1'b0;
            req_q    <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            phase_q  <= phase_d;
            ready_q  <= state_d == IDLE;
            busy_q   <= state_d == LOAD || state_d == RUN;
            absorb_q <= state_d == LOAD;
            en_q     <= state_d == LOAD || (state_d == RUN && phase_d == LAST_PH);
            req_q    <= state_d == RUN && phase_d == 2'd0;
            last_q   <= state_d == RUN && round_d == LAST_RND;
            done_q   <= state_d == DONE;
        end
    end
    assign bus.ReadyxSO     = ready_q;
    assign bus.BusyxSO      = busy_q;
    assign bus.AbsorbxSO    = absorb_q;
    // with one cycle per round the write coincides with the randomness request, so a stall must block it
    assign bus.StateEnxSO   = en_q && !(req_q && !bus.RandValidxSI);
    assign bus.RandReqxSO   = req_q;
    assign bus.RoundNrxDO   = round_q;
    assign bus.PhasexDO     = phase_q;
    assign bus.LastRoundxSO = last_q;
    assign bus.DonexSO      = done_q;
endmodule

// File: tb/tb_keccak_round_control.sv
// tb_keccak_round_control: random and directed stimulus against a step-count model of the round sequencer
module tb_keccak_round_control;
    typedef struct packed {
        logic       ready, busy, absorb, en, req, last, done;
        logic [4:0] round;
        logic [1:0] phase;
    } out_t;
    localparam int NR [2] = '{18, 12};
    localparam int RC [2] = '{2, 1};
    logic clk = 0, rst = 1, start = 0, rv = 1;
    int   checks = 0, failures = 0, cyc = 0, to_cnt = 0;
    int   ms [2] = '{-1, -1};
    int   lit_lat [2] = '{-1, -1};
    int   t0 [2] = '{0, 0}, en_cnt [2] = '{0, 0}, req_cnt [2] = '{0, 0}, stl [2] = '{0, 0};
    int   win_done = 0, ld = 0;
    bit   chk_en = 0, post_rst = 0, win = 0, win_q = 0, held = 0, ld_v = 0, fin = 0;
    out_t act [2];
    keccak_round_control_if ifa ();
    keccak_round_control_if ifb ();
    assign ifa.StartxSI     = start;
    assign ifa.RandValidxSI = rv;
    assign ifb.StartxSI     = start;
    assign ifb.RandValidxSI = rv;
    keccak_round_control dut_a (.ClkxCI(clk), .RstxRI(rst), .bus(ifa));
    keccak_round_control #(.NUM_ROUNDS(12), .ROUND_CYCLES(1)) dut_b (.ClkxCI(clk), .RstxRI(rst), .bus(ifb));
    assign act[0] = {ifa.ReadyxSO, ifa.BusyxSO, ifa.AbsorbxSO, ifa.StateEnxSO, ifa.RandReqxSO,
                     ifa.LastRoundxSO, ifa.DonexSO, ifa.RoundNrxDO, ifa.PhasexDO};
    assign act[1] = {ifb.ReadyxSO, ifb.BusyxSO, ifb.AbsorbxSO, ifb.StateEnxSO, ifb.RandReqxSO,
                     ifb.LastRoundxSO, ifb.DonexSO, ifb.RoundNrxDO, ifb.PhasexDO};
    always #5 clk = ~clk;
    // model: s=-1 idle, s=0 load, s=1..nr*rc run steps, s=nr*rc+1 done
    function automatic out_t model_out(input int s, input int nr, input int rc, input logic v);
        out_t e;
        int r, p;
        e = '0;
        if (s < 0) e.ready = 1;
        else if (s == 0) begin
            e.busy = 1; e.absorb = 1; e.en = 1;
        end else if (s <= nr * rc) begin
            r = (s - 1) / rc;
            p = (s - 1) % rc;
            e.busy = 1;
            e.round = 5'(r);
            e.phase = 2'(p);
            e.req = (p == 0);
            e.last = (r == nr - 1);
            e.en = (p == rc - 1) && !(p == 0 && !v);
        end else begin
            e.done = 1;
            e.round = 5'(nr - 1);
        end
        return e;
    endfunction
    function automatic int model_next(input int s, input int nr, input int rc, input logic st, input logic v, input logic rs);
        if (rs) return -1;
        if (s < 0) return st ? 0 : -1;
        if (s == 0) return 1;
        if (s <= nr * rc) return ((s - 1) % rc == 0 && !v) ? s : s + 1;
        return -1;
    endfunction
    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) ms[i] = model_next(ms[i], NR[i], RC[i], start, rv, rst);
    end
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_en) for (int i = 0; i < 2; i++) begin
                e = model_out(ms[i], NR[i], RC[i], rv);
                check($sformatf("dut%0d_outputs", i), int'(act[i]), int'(e));
                if (act[i].ready && start && !rst) begin
                    t0[i] = cyc; en_cnt[i] = 0; req_cnt[i] = 0; stl[i] = 0;
                end else begin
                    en_cnt[i] += int'(act[i].en);
                    req_cnt[i] += int'(act[i].req);
                    stl[i] += int'(act[i].req && !rv);
                end
                if (act[i].done) begin
                    check($sformatf("dut%0d_latency", i), cyc - t0[i], 2 + NR[i] * RC[i] + stl[i]);
                    check($sformatf("dut%0d_stateen_count", i), en_cnt[i], NR[i] + 1);
                    check($sformatf("dut%0d_randreq_count", i), req_cnt[i], NR[i] + stl[i]);
                    if (lit_lat[i] > 0) check($sformatf("dut%0d_latency_literal", i), cyc - t0[i], lit_lat[i]);
                end
            end
            if (post_rst) begin
                check("post_reset_ready", int'(act[0].ready), 1);
                check("post_reset_round", int'(act[0].round), 0);
                check("post_reset_done", int'(act[0].done), 0);
            end
            if (win && act[0].done) win_done++;
            if (win_q && !win) check("start_busy_done_count", win_done, 1);
            win_q = win;
            if (held && act[0].done) begin
                ld = cyc; ld_v = 1;
            end
            if (held && act[0].absorb && ld_v) check("held_start_gap", cyc - ld, 2);
            if (fin) begin
                check("wait_timeouts", to_cnt, 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic wait_done();
        int n = 0;
        while (!ifa.DonexSO && n < 200) begin
            step();
            n++;
        end
        if (!ifa.DonexSO) to_cnt++;
    endtask
    task automatic wait_round(input int r);
        int n = 0;
        while (!(ifa.BusyxSO && ifa.RoundNrxDO == 5'(r) && ifa.PhasexDO == 2'd0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) to_cnt++;
    endtask
    task automatic run(input int la, input int lb);
        lit_lat = '{la, lb};
        start = 1;
        step();
        start = 0;
        wait_done();
        step();
        lit_lat = '{-1, -1};
    endtask
    initial begin
        int n;
        step();
        chk_en = 1;
        step();
        rst = 0;
        post_rst = 1;
        step();
        post_rst = 0;
        repeat (9) step();
        run(38, 14);
        lit_lat = '{41, -1};
        start = 1;
        step();
        start = 0;
        wait_round(5);
        rv = 0;
        repeat (3) step();
        rv = 1;
        wait_done();
        step();
        lit_lat = '{-1, -1};
        start = 1;
        step();
        start = 0;
        wait_round(9);
        rst = 1;
        step();
        rst = 0;
        post_rst = 1;
        step();
        post_rst = 0;
        run(38, 14);
        win = 1;
        start = 1;
        step();
        start = 0;
        wait_round(3);
        start = 1;
        step();
        start = 0;
        wait_done();
        repeat (5) step();
        win = 0;
        step();
        held = 1;
        start = 1;
        repeat (100) step();
        n = 0;
        while (!ifa.AbsorbxSO && n < 100) begin
            step();
            n++;
        end
        if (!ifa.AbsorbxSO) to_cnt++;
        start = 0;
        wait_done();
        step();
        held = 0;
        step();
        repeat (3000) begin
            step();
            start = ($urandom_range(7) == 0);
            rv = ($urandom_range(3) != 0);
            rst = ($urandom_range(299) == 0);
        end
        start = 0;
        rv = 1;
        rst = 0;
        repeat (60) step();
        fin = 1;
    end
endmodule

// File: doc/keccak_round_control.md
Name: keccak_round_control

Overview:
- Round sequencer for the masked (DOM) Keccak-f[25*W] permutation.
- Drives the round number into the round-constant lookup and generates state-register load, absorb-mux and randomness-request strobes for the datapath.
- Sits directly upstream of the round-constant lookup and alongside the masked state register.
- Handles the start/done handshake with the surrounding sponge wrapper. Stalls rounds while fresh randomness is unavailable.

Parameters:
- NUM_ROUNDS, 18, rounds per permutation (12+2*log2(W) for W=8); legal range 1..24.
- ROUND_CYCLES, 2, cycles per round (DOM chi register stages + 1); legal range 1..4.

Ports:
- ClkxCI  in  1  clock, rising edge
- RstxRI  in  1  synchronous reset, active-high
- StartxSI  in  1  start request; sampled only in IDLE
- RandValidxSI  in  1  fresh masking randomness available this cycle
- ReadyxSO  out  1  high in IDLE only
- BusyxSO  out  1  high in LOAD and RUN
- AbsorbxSO  out  1  selects input data into state register (LOAD only)
- StateEnxSO  out  1  state register write enable
- RandReqxSO  out  1  datapath consumes randomness this cycle
- RoundNrxDO  out  5  current round index, feeds round-constant lookup
- PhasexDO  out  2  cycle index within current round
- LastRoundxSO  out  1  RoundNrxDO == NUM_ROUNDS-1 while in RUN
- DonexSO  out  1  one-cycle pulse, permutation result valid in state register

Behaviour:
- Reset (RstxRI=1 at a rising edge, any state, including mid-permutation): state IDLE, round=0, phase=0. Next cycle: ReadyxSO=1, all other outputs 0. No DonexSO for an aborted run.
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are decoded from registered state and counters (Moore), with no combinational path from inputs to outputs, except the RandValidxSI gating of StateEnxSO described below.
- IDLE:
  - ReadyxSO=1.
  - StartxSI=1 -> LOAD. Otherwise stay.
- LOAD (exactly 1 cycle):
  - AbsorbxSO=1, StateEnxSO=1, BusyxSO=1, round=0, phase=0.
  - -> RUN.
- RUN:
  - BusyxSO=1.
  - RandReqxSO=1 when phase==0.
  - StateEnxSO=1 when phase==ROUND_CYCLES-1 and the cycle is not stalled.
- Stall:
  - Condition: phase==0 and RandValidxSI==0.
  - Effect: round and phase hold, and RandReqxSO stays 1.
  - When ROUND_CYCLES=1, StateEnxSO is also forced 0 on a stalled cycle.
  - When ROUND_CYCLES>1, RandValidxSI is ignored for phase!=0.
- Advance (RUN, not stalled):
  - If phase<ROUND_CYCLES-1: phase+1.
  - Else phase=0, then:
    - if round<NUM_ROUNDS-1: round+1.
    - else -> DONE.
- DONE (exactly 1 cycle):
  - DonexSO=1, RoundNrxDO holds NUM_ROUNDS-1, all strobes 0.
  - -> IDLE, with round and phase cleared to 0 on that transition.
- StartxSI is ignored outside IDLE. It is not queued: a Start held high through DONE is re-sampled in IDLE, so a back-to-back run costs one IDLE cycle.
- Range:
  - RoundNrxDO never exceeds NUM_ROUNDS-1 (the lookup table has exactly NUM_ROUNDS entries).
  - PhasexDO never exceeds ROUND_CYCLES-1.
  - Counters never wrap.
- Latency with no stalls: StartxSI sampled in IDLE at edge t gives LOAD in cycle t+1, RUN in cycles t+2..t+1+NUM_ROUNDS*ROUND_CYCLES, and DONE in cycle t+2+NUM_ROUNDS*ROUND_CYCLES. With the default parameters, DONE is at t+38. Each stall cycle adds one cycle.
- StateEnxSO asserts exactly 1+NUM_ROUNDS times per completed run.
- RandReqxSO asserts NUM_ROUNDS + (number of stall cycles) times per completed run.

Test Plan:
- Reset then idle: hold RstxRI 2 cycles, StartxSI=0 for 10 cycles -> ReadyxSO=1, RoundNrxDO=0, all strobes 0 throughout.
- Single run, default parameters, RandValidxSI=1: pulse StartxSI -> AbsorbxSO=1 for exactly one cycle; RoundNrxDO steps 0..17, each value held 2 cycles; StateEnxSO high on PhasexDO=1; DonexSO pulses 38 cycles after the start edge; 19 StateEnxSO pulses in total.
- Randomness stall: RandValidxSI=0 for 3 cycles at round 5 phase 0 -> RoundNrxDO stays 5, PhasexDO stays 0, RandReqxSO stays 1, no StateEnxSO; DonexSO arrives 3 cycles later (start+41).
- Reset mid-run: assert RstxRI at round 9 -> next cycle IDLE, RoundNrxDO=0, ReadyxSO=1, no DonexSO; a fresh Start completes normally in 38 cycles.
- Start while busy / held Start: StartxSI pulsed at round 3 is ignored (Done count=1). StartxSI held high continuously -> runs repeat with DONE->IDLE->LOAD, i.e. one idle cycle between runs.
- ROUND_CYCLES=1, NUM_ROUNDS=12: StateEnxSO and RandReqxSO coincide every RUN cycle; RandValidxSI=0 suppresses StateEnxSO; DonexSO at start+14 with no stalls.
